mem_bus_arbiter: RTL and testbench

- Shares the single main-memory port between two requesters: the two core-side miss/writeback paths of the shared cache.
- Round-robin grant; one transaction outstanding at a time.
- Latches the winner's command and drives the memory request/ready handshake.
- Returns read data and a one-cycle ready pulse to the granted requester.
- A watchdog terminates transactions that memory never completes, reporting an error instead of hanging the system.

---
 rtl/mem_bus_pkg.sv | 10 +
 rtl/mem_bus_arbiter_rr_arb2.sv | 20 ++
 rtl/mem_bus_arbiter.sv | 81 ++++++++
 tb/tb_mem_bus_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and constants for the memory bus arbiter
package mem_bus_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
  localparam int NUM_REQ = 2;
  localparam logic [63:0] ERR_RDATA = '1;
endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick with a pointer register favouring the requester not last served
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       last_grant,
  output logic [1:0] grant_onehot,
  output logic       grant_idx
);
  logic ptr;
  always_ff @(posedge clk) begin
    if (reset) ptr <= 1'b0;
    else if (update) ptr <= ~last_grant;
  end
  always_comb begin
    grant_idx    = (req[0] & req[1]) ? ptr : req[1];
    grant_onehot = (req == 2'b00) ? 2'b00 : (grant_idx ? 2'b10 : 2'b01);
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between two requesters, one transaction at a time, with a watchdog
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      req_err,
  output logic                      mem_req,
  output logic                      mem_rw,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_data_out,
  input  logic [DATA_W-1:0]         mem_data_in,
  input  logic                      mem_ready,
  output logic                      grant_id
);
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  state_t state, state_n;
  logic [1:0] gnt_oh;
  logic gnt_idx, timeout, finish;
  logic [WD_W-1:0] wdog;
  rr_arb2 u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (req_valid),
    .update      (state == DONE),
    .last_grant  (grant_id),
    .grant_onehot(gnt_oh),
    .grant_idx   (gnt_idx)
  );
  always_comb begin
    timeout = (TIMEOUT_CYCLES != 0) && (wdog == WD_W'(TIMEOUT_CYCLES - 1));
    finish  = mem_ready || timeout;
    state_n = (state == IDLE) ? (|gnt_oh ? BUSY : IDLE) :
              (state == BUSY) ? (finish ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      mem_req      <= 1'b0;
      mem_rw       <= 1'b0;
      mem_addr     <= '0;
      mem_data_out <= '0;
      req_ready    <= '0;
      req_rdata    <= '0;
      req_err      <= 1'b0;
      grant_id     <= 1'b0;
      wdog         <= '0;
    end else begin
      state     <= state_n;
      req_ready <= '0;
      if (state == IDLE && |gnt_oh) begin
        mem_req      <= 1'b1;
        mem_rw       <= req_rw[gnt_idx];
        mem_addr     <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
        mem_data_out <= req_wdata[gnt_idx*DATA_W +: DATA_W];
        grant_id     <= gnt_idx;
        wdog         <= '0;
      end
      if (state == BUSY) begin
        if (!mem_ready) wdog <= wdog + 1'b1;
        // mem_ready takes precedence over a simultaneous timeout
        if (finish) begin
          mem_req             <= 1'b0;
          req_ready[grant_id] <= 1'b1;
          req_err             <= !mem_ready;
          req_rdata           <= !mem_ready ? ERR_RDATA[DATA_W-1:0] : (mem_rw ? '0 : mem_data_in);
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
  logic        clk = 0;
  logic        reset;
  logic [1:0]  req_valid, req_rw, req_ready;
  logic [63:0] req_addr, req_wdata;
  logic [31:0] req_rdata, mem_addr, mem_data_out, mem_data_in;
  logic        req_err, mem_req, mem_rw, mem_ready, grant_id;
  int total = 0, passed = 0, hi;
  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .req_rdata(req_rdata), .req_err(req_err),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in), .mem_ready(mem_ready), .grant_id(grant_id)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  initial begin
    reset = 1; req_valid = 0; req_rw = 0; req_addr = 0; req_wdata = 0;
    mem_data_in = 0; mem_ready = 0;
    tick(); tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_rdata", req_rdata, 0);
    chk("rst_err", req_err, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_gid", grant_id, 0);
    reset = 0;
    // single read, memory answers 3 cycles after mem_req
    req_valid = 2'b01; req_rw = 2'b00; req_addr = {32'h0, 32'h40};
    tick();
    chk("rd_mem_req", mem_req, 1);
    chk("rd_addr", mem_addr, 32'h40);
    chk("rd_rw", mem_rw, 0);
    tick(); tick();
    mem_ready = 1; mem_data_in = 32'hCAFE_0001;
    chk("rd_no_early_ready", req_ready, 0);
    tick();
    mem_ready = 0; req_valid = 0;
    chk("rd_ready", req_ready, 2'b01);
    chk("rd_rdata", req_rdata, 32'hCAFE_0001);
    chk("rd_err", req_err, 0);
    chk("rd_mem_req_drop", mem_req, 0);
    tick();
    chk("rd_ready_pulse", req_ready, 0);
    chk("rd_rdata_hold", req_rdata, 32'hCAFE_0001);
    // simultaneous requests from pointer reset
    reset = 1; tick(); reset = 0;
    req_valid = 2'b11; req_rw = 2'b01; req_addr = {32'h20, 32'h10}; req_wdata = {32'h0, 32'h1111_1111};
    tick();
    chk("sim_gid0", grant_id, 0);
    chk("sim_wr_rw", mem_rw, 1);
    chk("sim_wr_addr", mem_addr, 32'h10);
    chk("sim_wr_data", mem_data_out, 32'h1111_1111);
    mem_ready = 1; mem_data_in = 32'h9999_9999;
    tick();
    mem_ready = 0; req_valid = 2'b10;
    chk("sim_ready0", req_ready, 2'b01);
    chk("sim_wr_rdata", req_rdata, 0);
    tick(); tick();
    chk("sim_gid1", grant_id, 1);
    chk("sim_rd_addr", mem_addr, 32'h20);
    chk("sim_rd_rw", mem_rw, 0);
    mem_ready = 1; mem_data_in = 32'h0000_BEEF;
    tick();
    mem_ready = 0; req_valid = 0;
    chk("sim_ready1", req_ready, 2'b10);
    chk("sim_rd_rdata", req_rdata, 32'h0000_BEEF);
    tick();
    // fairness: both held continuously, latency 1
    req_valid = 2'b11; req_rw = 2'b00;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("fair_gid%0d", i), grant_id, 64'(i % 2));
      chk($sformatf("fair_addr%0d", i), mem_addr, (i % 2) ? 32'h20 : 32'h10);
      mem_ready = 1; mem_data_in = 32'(i);
      tick();
      mem_ready = 0;
      chk($sformatf("fair_ready%0d", i), req_ready, (i % 2) ? 2'b10 : 2'b01);
      tick();
    end
    req_valid = 0;
    tick();
    // timeout on requester 1
    req_valid = 2'b10; req_rw = 2'b00; req_addr = {32'h30, 32'h44};
    tick();
    chk("to_gid", grant_id, 1);
    hi = 0;
    for (int n = 0; n < 20 && mem_req; n++) begin
      hi++;
      tick();
    end
    req_valid = 0;
    chk("to_req_cycles", hi, 8);
    chk("to_ready", req_ready, 2'b10);
    chk("to_err", req_err, 1);
    chk("to_rdata", req_rdata, 32'hFFFF_FFFF);
    tick();
    req_valid = 2'b01;
    tick();
    chk("post_to_gid", grant_id, 0);
    chk("post_to_addr", mem_addr, 32'h44);
    mem_ready = 1; mem_data_in = 32'h1234;
    tick();
    mem_ready = 0; req_valid = 0;
    chk("post_to_ready", req_ready, 2'b01);
    chk("post_to_err", req_err, 0);
    chk("post_to_rdata", req_rdata, 32'h1234);
    tick();
    // reset mid-transaction, pointer currently favours requester 1
    req_valid = 2'b01; req_addr = {32'h30, 32'h50};
    tick(); tick(); tick();
    reset = 1; req_valid = 0;
    tick();
    reset = 0;
    chk("mid_rst_mem_req", mem_req, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_state", dut.state, 0);
    chk("mid_rst_ptr", dut.u_arb.ptr, 0);
    mem_ready = 1; mem_data_in = 32'h7777;
    tick();
    mem_ready = 0;
    chk("late_ready", req_ready, 0);
    tick();
    chk("late_ready2", req_ready, 0);
    // both request after reset: pointer back at 0
    req_valid = 2'b11; req_rw = 2'b00; req_addr = {32'h60, 32'h70};
    tick();
    chk("ptr_gid", grant_id, 0);
    mem_ready = 1; mem_data_in = 32'h5A5A;
    tick();
    mem_ready = 0; req_valid = 0;
    chk("ptr_rdata", req_rdata, 32'h5A5A);
    tick();
    // stray mem_ready while idle
    mem_ready = 1; mem_data_in = 32'hDEAD;
    tick(); tick();
    mem_ready = 0;
    chk("stray_ready", req_ready, 0);
    chk("stray_rdata", req_rdata, 32'h5A5A);
    chk("stray_mem_req", mem_req, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
